// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
// State encodings, error codes and the default sync marker.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Payload buffer access bus between the parser and its storage.
// Master writes bytes and supplies the read address; slave returns data.
interface uart_frame_parser_if #(
  parameter int AW = 4
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;

  modport master (
    output we, waddr, wdata, raddr,
    input  rdata
  );

  modport slave (
    input  we, waddr, wdata, raddr,
    output rdata
  );
endinterface

// File: rtl/frame_payload_buf.sv
// Payload byte store: one write port, one asynchronous read port.
// Contents are never cleared; only bytes of a checked frame are read.
module frame_payload_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input logic                clk_i,
  uart_frame_parser_if.slave bus
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (bus.we) begin
      mem_q[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.rdata = mem_q[bus.raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC/LEN/payload/CSUM frames from a UART byte stream
// and replays checked payloads over a valid/ready byte port.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 208320
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Data_Valid,
  output logic [7:0] o_Data_Byte,
  input  logic       i_Data_Ready,
  output logic       o_Frame_Last,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Overrun
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam logic [7:0]    MAX_B   = 8'(MAX_LEN);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);

  state_e        state_q;
  logic [IW-1:0] len_q;
  logic [IW-1:0] wr_q;
  logic [IW-1:0] rd_q;
  logic [7:0]    acc_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          last_q;
  logic          err_q;
  logic [1:0]    code_q;
  logic          ovr_q;

  logic          xfer;
  logic [IW-1:0] wr_d;
  logic [IW-1:0] rd_d;

  assign xfer = valid_q & i_Data_Ready;
  assign wr_d = wr_q + 1'b1;
  assign rd_d = rd_q + 1'b1;

  uart_frame_parser_if #(.AW(AW)) buf_if ();

  assign buf_if.we    = (state_q == ST_PAYLOAD) & i_Rx_DV;
  assign buf_if.waddr = wr_q[AW-1:0];
  assign buf_if.wdata = i_Rx_Byte;
  assign buf_if.raddr = rd_q[AW-1:0];

  frame_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk_i (i_Clock),
    .bus   (buf_if)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ovr_q   <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
      ovr_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
            state_q <= ST_LEN;
          end
        end
        ST_LEN, ST_PAYLOAD, ST_CSUM: begin
          // A byte on the terminal count wins over the timeout
          if (i_Rx_DV) begin
            cnt_q <= '0;
            unique case (1'b1)
              (state_q == ST_LEN): begin
                if (i_Rx_Byte == 8'h00 || i_Rx_Byte > MAX_B) begin
                  err_q   <= 1'b1;
                  code_q  <= ERR_LEN;
                  state_q <= ST_IDLE;
                end else begin
                  len_q   <= i_Rx_Byte[IW-1:0];
                  acc_q   <= i_Rx_Byte;
                  wr_q    <= '0;
                  state_q <= ST_PAYLOAD;
                end
              end
              (state_q == ST_PAYLOAD): begin
                acc_q <= acc_q ^ i_Rx_Byte;
                wr_q  <= wr_d;
                if (wr_d == len_q) begin
                  state_q <= ST_CSUM;
                end
              end
              default: begin
                if (i_Rx_Byte == acc_q) begin
                  rd_q    <= '0;
                  valid_q <= 1'b1;
                  last_q  <= (len_q == IW'(1));
                  state_q <= ST_DRAIN;
                end else begin
                  err_q   <= 1'b1;
                  code_q  <= ERR_CSUM;
                  state_q <= ST_IDLE;
                end
              end
            endcase
          end else if (cnt_q == TO_LAST) begin
            cnt_q   <= '0;
            err_q   <= 1'b1;
            code_q  <= ERR_TIMEOUT;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          ovr_q <= i_Rx_DV;
          if (xfer) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              rd_q   <= rd_d;
              last_q <= (rd_d == len_q - 1'b1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Data_Valid = valid_q;
  assign o_Data_Byte  = valid_q ? buf_if.rdata : 8'h00;
  assign o_Frame_Last = last_q;
  assign o_Frame_Err  = err_q;
  assign o_Err_Code   = code_q;
  assign o_Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_uart_frame_parser;

  localparam int MAXL = 16;
  localparam int TO   = 40;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_b  = 8'h00;
  logic       rdy   = 1'b1;
  logic       dv_o;
  logic [7:0] byte_o;
  logic       last_o;
  logic       err_o;
  logic [1:0] code_o;
  logic       ovr_o;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (rx_dv),
    .i_Rx_Byte    (rx_b),
    .o_Data_Valid (dv_o),
    .o_Data_Byte  (byte_o),
    .i_Data_Ready (rdy),
    .o_Frame_Last (last_o),
    .o_Frame_Err  (err_o),
    .o_Err_Code   (code_o),
    .o_Overrun    (ovr_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_dv_cyc = 0;
  int err_cyc = 0;
  bit started = 1'b0;

  logic [7:0] frm[$];
  logic [7:0] outq[$];
  bit         coll = 1'b0;
  int         idle_n = 0;
  logic       ev = 1'b0;
  logic       el = 1'b0;
  logic       ee = 1'b0;
  logic       eo = 1'b0;
  logic [7:0] eb = 8'h00;
  logic [1:0] ec = 2'd0;

  logic [7:0] got[$];
  bit         lasts[$];
  int         errs[$];
  int         ovr_n = 0;

  // Reference: collect whole frames, verify, then replay from a queue
  always @(posedge clk) begin : model
    logic [7:0] x;
    cyc++;
    started = 1'b1;
    if (rx_dv) last_dv_cyc = cyc;
    ee = 1'b0;
    ec = 2'd0;
    eo = 1'b0;
    if (rst) begin
      coll = 1'b0;
      frm.delete();
      outq.delete();
      idle_n = 0;
    end else if (outq.size() != 0) begin
      if (rx_dv) eo = 1'b1;
      if (rdy) void'(outq.pop_front());
    end else if (coll) begin
      if (rx_dv) begin
        idle_n = 0;
        frm.push_back(rx_b);
        if (frm.size() == 1) begin
          if (rx_b == 8'h00 || int'(rx_b) > MAXL) begin
            ee = 1'b1;
            ec = 2'd1;
            coll = 1'b0;
          end
        end else if (frm.size() == int'(frm[0]) + 2) begin
          x = 8'h00;
          for (int i = 0; i < frm.size() - 1; i++) x ^= frm[i];
          if (x == frm[frm.size()-1]) begin
            for (int i = 1; i < frm.size() - 1; i++)
              outq.push_back(frm[i]);
          end else begin
            ee = 1'b1;
            ec = 2'd2;
          end
          coll = 1'b0;
        end
      end else begin
        idle_n++;
        if (idle_n == TO) begin
          ee = 1'b1;
          ec = 2'd3;
          coll = 1'b0;
        end
      end
    end else if (rx_dv && rx_b == 8'hA5) begin
      coll = 1'b1;
      frm.delete();
      idle_n = 0;
    end
    ev = (outq.size() != 0);
    eb = ev ? outq[0] : 8'h00;
    el = (outq.size() == 1);
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({dv_o, byte_o, last_o, err_o, code_o, ovr_o} !==
          {ev, eb, el, ee, ec, eo}) begin
        errors++;
        $display("FAIL outputs cyc %0d: got v=%b d=%h l=%b e=%b c=%0d o=%b required v=%b d=%h l=%b e=%b c=%0d o=%b",
                 cyc, dv_o, byte_o, last_o, err_o, code_o, ovr_o,
                 ev, eb, el, ee, ec, eo);
      end
      if (dv_o && rdy) begin
        got.push_back(byte_o);
        lasts.push_back(last_o);
      end
      if (err_o) begin
        errs.push_back(int'(code_o));
        err_cyc = cyc;
      end
      if (ovr_o) ovr_n++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic clear();
    got.delete();
    lasts.delete();
    errs.delete();
    ovr_n = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_dv = 1'b1;
    rx_b = b;
    @(posedge clk);
    #1 rx_dv = 1'b0;
    rx_b = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int nl;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out", {dv_o, byte_o, last_o, err_o, code_o, ovr_o}, 0);

    clear();
    send(8'hA5); send(8'h03); send(8'h11);
    send(8'h22); send(8'h33); send(8'h03);
    idle(6);
    chk("good_n", got.size(), 3);
    chk("good_bytes", {got[0], got[1], got[2]}, 24'h112233);
    chk("good_last", {lasts[0], lasts[1], lasts[2]}, 3'b001);
    chk("good_err", errs.size(), 0);

    clear();
    send(8'hA5); send(8'h03); send(8'h11);
    send(8'h22); send(8'h33); send(8'h04);
    idle(4);
    chk("csum_n", errs.size(), 1);
    chk("csum_code", errs[0], 2);
    chk("csum_nodata", got.size(), 0);

    clear();
    send(8'h00); send(8'hFF); send(8'hA5);
    send(8'h00); send(8'hA5); send(8'h11);
    idle(4);
    chk("len_n", errs.size(), 2);
    chk("len_codes", errs[0] * 4 + errs[1], 5);

    clear();
    rdy = 1'b0;
    send(8'hA5); send(8'h03); send(8'h11);
    send(8'h22); send(8'h33); send(8'h03);
    idle(1);
    send(8'h55);
    @(negedge clk);
    chk("bp_hold", {dv_o, byte_o, last_o}, {1'b1, 8'h11, 1'b0});
    @(posedge clk);
    #1 rdy = 1'b1;
    idle(6);
    chk("bp_n", got.size(), 3);
    chk("bp_bytes", {got[0], got[1], got[2]}, 24'h112233);
    chk("bp_ovr", ovr_n, 1);
    chk("bp_err", errs.size(), 0);

    clear();
    send(8'hA5); send(8'h02); send(8'h11);
    idle(TO + 5);
    chk("to_n", errs.size(), 1);
    chk("to_code", errs[0], 3);
    chk("to_delay", err_cyc - last_dv_cyc, TO);
    clear();
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    idle(4);
    chk("to_next", {got.size(), got[0]}, {32'd1, 8'h7E});

    clear();
    send(8'hA5); send(8'h03); send(8'h11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {dv_o, byte_o, last_o, err_o, code_o, ovr_o}, 0);
    send(8'hA5); send(8'h03); send(8'hAA);
    send(8'hBB); send(8'hCC); send(8'hDE);
    idle(6);
    chk("rst_err", errs.size(), 0);
    chk("rst_n", got.size(), 3);
    chk("rst_bytes", {got[0], got[1], got[2]}, 24'hAABBCC);

    clear();
    send(8'hA5); send(8'h10);
    for (int i = 1; i <= MAXL; i++) send(8'(i));
    send(8'h00);
    idle(MAXL + 4);
    nl = 0;
    foreach (lasts[i]) nl += int'(lasts[i]);
    chk("max_n", got.size(), 16);
    chk("max_tail", {got[0], got[15], 7'd0, lasts[15]}, 24'h011001);
    chk("max_last_cnt", nl, 1);
    chk("max_err", errs.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, is the frame start marker.
REQ-002 Parameter MAX_LEN, default 16, is the maximum payload length in bytes.
REQ-003 Parameter TIMEOUT_CLKS, default 208320, is the inter-byte timeout in clocks (two 10-bit UART byte times at 10416 clocks per bit).
REQ-004 Port i_Clock, input, 1 bit: master clock; the block has one clock.
REQ-005 Port i_Reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port i_Rx_DV, input, 1 bit: one-cycle strobe from the UART receiver marking a received byte.
REQ-007 Port i_Rx_Byte, input, 8 bits: received byte, valid only while i_Rx_DV=1.
REQ-008 Port o_Data_Valid, output, 1 bit: a payload byte is presented.
REQ-009 Port o_Data_Byte, output, 8 bits: the presented payload byte.
REQ-010 Port i_Data_Ready, input, 1 bit: consumer accepts the byte; a transfer occurs when o_Data_Valid=1 and i_Data_Ready=1 in the same cycle.
REQ-011 Port o_Frame_Last, output, 1 bit: the presented byte is the final payload byte of the frame.
REQ-012 Port o_Frame_Err, output, 1 bit: one-cycle pulse when a frame is rejected.
REQ-013 Port o_Err_Code, output, 2 bits: 1 = bad length, 2 = bad checksum, 3 = timeout; valid only during the o_Frame_Err pulse, 0 otherwise.
REQ-014 Port o_Overrun, output, 1 bit: one-cycle pulse when a received byte is dropped during DRAIN.

Function
REQ-015 The frame format SHALL be SYNC_BYTE, LEN, LEN payload bytes, CSUM, where CSUM = LEN XOR all payload bytes.
REQ-016 The state machine SHALL have the states IDLE, LEN, PAYLOAD, CSUM and DRAIN; state changes occur only on i_Rx_DV, on timeout, or on a transfer.
REQ-017 IDLE: on a byte equal to SYNC_BYTE, go to LEN; all other bytes are silently discarded.
REQ-018 LEN: a byte of 0 or greater than MAX_LEN pulses o_Frame_Err with code 1 and returns to IDLE.
REQ-019 LEN: any other byte latches the length, seeds the checksum accumulator with that byte, clears the write index, and goes to PAYLOAD.
REQ-020 PAYLOAD: each byte is written to buffer[write index], XORed into the accumulator, and the write index increments; after the LEN-th byte, go to CSUM.
REQ-021 CSUM: if the byte equals the accumulator, clear the read index and go to DRAIN; otherwise pulse o_Frame_Err with code 2 and go to IDLE.
REQ-022 DRAIN: o_Data_Valid=1 and o_Data_Byte=buffer[read index]; the read index advances on each transfer.
REQ-023 DRAIN: o_Frame_Last=1 exactly when the read index equals LEN-1.
REQ-024 DRAIN: the transfer of the last byte returns the block to IDLE, with o_Data_Valid=0 in the following cycle.
REQ-025 o_Data_Byte and o_Frame_Last SHALL hold stable while o_Data_Valid=1 and i_Data_Ready=0.
REQ-026 Bytes arriving in DRAIN SHALL be dropped and pulse o_Overrun; a SYNC_BYTE arriving in DRAIN is not honoured.
REQ-027 Outside DRAIN, o_Data_Valid and o_Frame_Last SHALL be 0.
REQ-028 In LEN, PAYLOAD and CSUM, a timeout counter clears on every i_Rx_DV and otherwise increments.
REQ-029 When the timeout counter reaches TIMEOUT_CLKS-1, the block pulses o_Frame_Err with code 3 and goes to IDLE.
REQ-030 If i_Rx_DV coincides with the timeout terminal count, the byte SHALL be processed and the timeout ignored.
REQ-031 The timeout counter SHALL be held at 0 in IDLE and DRAIN.
REQ-032 Latency: o_Data_Valid SHALL rise in the cycle after the i_Rx_DV that carries a correct CSUM.
REQ-033 Error pulses SHALL occur in the cycle after the offending i_Rx_DV, or in the cycle after the timeout terminal count.
REQ-034 Counter width SHALL be ceil(log2(TIMEOUT_CLKS)) bits; index widths SHALL be ceil(log2(MAX_LEN+1)) bits; no wrap-around is reachable.

Reset
REQ-035 While i_Reset=1 at a clock edge, the state SHALL become IDLE and all outputs, indices, the accumulator and the counter SHALL become 0.
REQ-036 Reset asserted mid-frame or mid-DRAIN SHALL discard the frame with no error pulse; buffer contents need not be cleared.

Structure
REQ-037 A shared package uart_frame_pkg SHALL hold the state encodings, the error-code constants and the default SYNC_BYTE.
REQ-038 One sub-module, frame_payload_buf (MAX_LEN x 8 register array, one write port, one asynchronous read port), is natural; all other logic stays in uart_frame_parser.

Verification
REQ-039 Good frame: bytes A5 03 11 22 33 03 -> 11, 22, 33 out in order; o_Frame_Last=1 only on 33; no error.
REQ-040 Bad checksum: bytes A5 03 11 22 33 04 -> o_Frame_Err pulse with code 2; o_Data_Valid never 1.
REQ-041 Bad length and junk: bytes 00 FF A5 00, then A5 11 -> two o_Frame_Err pulses with code 1 (0 and 17 > MAX_LEN); leading 00 FF ignored.
REQ-042 Backpressure/overrun: good frame with i_Data_Ready=0 for 5 cycles and a byte 55 received during DRAIN -> o_Data_Byte held at 11, one o_Overrun pulse, all 3 bytes still delivered.
REQ-043 Timeout: bytes A5 02 11, then idle -> o_Frame_Err with code 3 exactly TIMEOUT_CLKS cycles after the last strobe; the next good frame parses.
REQ-044 Reset mid-PAYLOAD: i_Reset for 1 cycle after A5 03 11 -> all outputs 0, no error; a following good frame is delivered intact.
